// File: rtl/int_to_float_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_float_pkg
//  Description : Shared constants and FSM state encoding for the
//                integer-to-float32 converter.
//  Revision    : 1.0  initial release
// ============================================================================
package int_to_float_pkg;

    // float32 exponent bias
    localparam logic [7:0] c_float_bias = 8'd127;

    // Converter sequencing states (3-bit codes shared with the FPU blocks)
    typedef enum logic [2:0] {
        GET_A     = 3'd0,
        CONVERT_0 = 3'd1,
        CONVERT_1 = 3'd2,
        CONVERT_2 = 3'd3,
        ROUND     = 3'd4,
        PACK      = 3'd5,
        PUT_Z     = 3'd6
    } state_t;

endpackage : int_to_float_pkg
`default_nettype wire

// File: rtl/int_to_float.sv
`default_nettype none
// ============================================================================
//  Module      : int_to_float
//  Description : Signed 32-bit integer to IEEE-754 single-precision float,
//                round to nearest / ties to even, stb/ack streaming handshake
//                on both sides. One operand in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module int_to_float
    import int_to_float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_t             r_state;
    logic [31:0]        r_a;
    logic [31:0]        r_value;
    logic               r_z_s;
    logic signed [7:0]  r_z_e;
    logic [23:0]        r_z_m;
    logic               r_guard;
    logic               r_round_bit;
    logic               r_sticky;
    logic [31:0]        r_z;
    logic               r_input_a_ack;
    logic [31:0]        r_output_z;
    logic               r_output_z_stb;

    // Conversion sequencer: accept, normalise one bit per cycle, round, pack, emit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= GET_A;
            r_input_a_ack  <= 1'b0;
            r_output_z_stb <= 1'b0;
            r_output_z     <= 32'h0;
        end else begin
            case (r_state)
                GET_A: begin
                    r_input_a_ack <= 1'b1;
                    if (r_input_a_ack && input_a_stb) begin
                        r_a           <= input_a;
                        r_input_a_ack <= 1'b0;
                        r_state       <= CONVERT_0;
                    end
                end

                CONVERT_0: begin
                    if (r_a == 32'h0) begin
                        // Zero short-cuts straight to output; never yields -0
                        r_z     <= 32'h0;
                        r_state <= PUT_Z;
                    end else begin
                        // -2^31 negates to itself; read as unsigned magnitude
                        r_z_s   <= r_a[31];
                        r_value <= r_a[31] ? (32'h0 - r_a) : r_a;
                        r_z_e   <= 8'sd31;
                        r_state <= CONVERT_1;
                    end
                end

                CONVERT_1: begin
                    if (!r_value[31]) begin
                        r_value <= r_value << 1;
                        r_z_e   <= r_z_e - 8'sd1;
                    end else begin
                        r_state <= CONVERT_2;
                    end
                end

                CONVERT_2: begin
                    r_z_m       <= r_value[31:8];
                    r_guard     <= r_value[7];
                    r_round_bit <= r_value[6];
                    r_sticky    <= |r_value[5:0];
                    r_state     <= ROUND;
                end

                ROUND: begin
                    if (r_guard && (r_round_bit || r_sticky || r_z_m[0])) begin
                        r_z_m <= r_z_m + 24'd1;
                        // Mantissa wraps to zero; the exponent absorbs the carry
                        if (r_z_m == 24'hffffff) begin
                            r_z_e <= r_z_e + 8'sd1;
                        end
                    end
                    r_state <= PACK;
                end

                PACK: begin
                    // Exponent is at most 31, so no overflow or denormal handling
                    r_z     <= {r_z_s, r_z_e[7:0] + c_float_bias, r_z_m[22:0]};
                    r_state <= PUT_Z;
                end

                PUT_Z: begin
                    r_output_z_stb <= 1'b1;
                    r_output_z     <= r_z;
                    if (r_output_z_stb && output_z_ack) begin
                        r_output_z_stb <= 1'b0;
                        r_state        <= GET_A;
                    end
                end

                default: begin
                    r_state <= GET_A;
                end
            endcase
        end
    end

    assign input_a_ack  = r_input_a_ack;
    assign output_z     = r_output_z;
    assign output_z_stb = r_output_z_stb;

endmodule : int_to_float
`default_nettype wire
